// File: rtl/fmul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add, 2-cycle normalise/round.
// Define FMUL_SPECIAL_EN to add NaN/infinity handling; otherwise exponent 255 is ordinary.
module fmul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         ovf,
    output logic         unf
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t             state, state_nx;
    logic [4:0]         cnt;
    logic               step;
    logic [47:0]        prod;
    logic [47:0]        mcand;
    logic [23:0]        mplier;
    logic               sign;
    logic               zero;
    logic signed [9:0]  exp;
    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
`ifdef FMUL_SPECIAL_EN
    logic               nan;
    logic               inf;
`endif

    logic [7:0]         ea, eb;
    logic               rnd_up;
    logic [23:0]        sum;
    logic signed [9:0]  exp_f;
    logic               accept;

    assign ea        = a[30:23];
    assign eb        = b[30:23];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Round to nearest-even; carry into bit 23 means the mantissa wrapped to 1.0
    assign rnd_up = guard & (sticky | frac[0]);
    assign sum    = {1'b0, frac} + {23'b0, rnd_up};
    assign exp_f  = exp + $signed({9'b0, sum[23]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid)        state_nx = MUL;
            MUL:  if (cnt == 5'd23)    state_nx = NORM;
            NORM: if (step)            state_nx = DONE;
            DONE: if (out_ready)       state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            step   <= 1'b0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign   <= 1'b0;
            zero   <= 1'b0;
            exp    <= '0;
            frac   <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
            out    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
`ifdef FMUL_SPECIAL_EN
            nan    <= 1'b0;
            inf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    step   <= 1'b0;
                    prod   <= '0;
                    mcand  <= {24'b0, 1'b1, a[22:0]};
                    mplier <= {1'b1, b[22:0]};
                    sign   <= a[31] ^ b[31];
                    zero   <= (ea == 8'd0) || (eb == 8'd0);
                    exp    <= $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
`ifdef FMUL_SPECIAL_EN
                    nan    <= ((&ea) && (|a[22:0])) || ((&eb) && (|b[22:0]))
                           || (((&ea) || (&eb)) && ((ea == 8'd0) || (eb == 8'd0)));
                    inf    <= (&ea) || (&eb);
`endif
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                NORM: begin
                    step <= 1'b1;
                    if (!step) begin
                        if (prod[47]) begin
                            frac   <= prod[46:24];
                            guard  <= prod[23];
                            sticky <= |prod[22:0];
                            exp    <= exp + 10'sd1;
                        end else begin
                            frac   <= prod[45:23];
                            guard  <= prod[22];
                            sticky <= |prod[21:0];
                        end
                    end else begin
                        ovf <= 1'b0;
                        unf <= 1'b0;
`ifdef FMUL_SPECIAL_EN
                        if (nan)
                            out <= 32'h7FC0_0000;
                        else if (inf)
                            out <= {sign, 8'hFF, 23'h0};
                        else
`endif
                        if (zero) begin
                            out <= {sign, 31'h0};
                        end else if (exp_f >= 10'sd255) begin
                            out <= {sign, 8'hFF, 23'h0};
                            ovf <= 1'b1;
                        end else if (exp_f <= 10'sd0) begin
                            out <= {sign, 31'h0};
                            unf <= 1'b1;
                        end else begin
                            out <= {sign, exp_f[7:0], sum[22:0]};
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_seq.sv
// Scoreboard bench for fmul_seq: directed vectors, decoupled driver and monitor.
// Checks results, flags, fixed latency, output stall stability and mid-operation reset.
module tb_fmul_seq;

    typedef struct {
        logic [31:0] o;
        logic        ov;
        logic        un;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        ovf;
    logic        unf;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          seen = 0;
    bit          hs = 0;
    logic [31:0] held;

    fmul_seq #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compares whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            hs   = 0;
        end else begin
            if (hs) begin
                chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
                hs = 0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got out=%h expected no result", out);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].due);
                        seen = 1;
                        held = out;
                    end else begin
                        chk("out_stable", out, held);
                    end
                    chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                    if (out_ready) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out", out, e.o);
                        chk("ovf", {31'b0, ovf}, {31'b0, e.ov});
                        chk("unf", {31'b0, unf}, {31'b0, e.un});
                        n_vec++;
                        seen = 0;
                        hs   = 1;
                    end
                end
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the accept edge
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eo, input logic eov, input logic eun);
        bit ok;
        exp_t e;
        ok = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            e.o = eo; e.ov = eov; e.un = eun; e.due = cyc + 1 + 26;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eo, input logic eov, input logic eun);
        issue(ia, ib, eo, eov, eun);
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", {30'b0, ovf, unf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        run(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0);
        run(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 0, 0);
        run(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 0, 0);
        run(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 0, 0);
        run(32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, 0, 0);
        run(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 0, 0);
        run(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 0, 0);
        run(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1, 0);
        run(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 0, 1);
`ifdef FMUL_SPECIAL_EN
        run(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 0, 0);
        run(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 0);
        run(32'h7FC0_1234, 32'h4000_0000, 32'h7FC0_0000, 0, 0);
`else
        run(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1, 0);
`endif

        // Output stall, then back-to-back accept after the handshake
        out_ready = 1'b0;
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0);
        for (int t = 0; t < 100 && !out_valid; t++) @(posedge clk);
        #1;
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 0, 0);
        wait_done();

        // Reset in the middle of the multiply
        issue(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out", out, 32'd0);
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        run(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
